// File: rtl/fusion_frame_sequencer_pkg.sv
// Shared definitions for the frame-fusion sequencer: phase encodings,
// frame-geometry helper and the layout of the write-back tag word.
package fusion_pkg;

  typedef enum logic {
    STATE_AVG  = 1'b0,
    STATE_FUSE = 1'b1
  } fusion_state_e;

  // Beats per frame for a given geometry and datapath width.
  function automatic int unsigned calc_beats(input int unsigned im_len,
                                             input int unsigned im_wid,
                                             input int unsigned units);
    return (im_len * im_wid) / units;
  endfunction

  // Tag word, MSB to LSB: {valid, mode, init, addr[ADDR_W-1:0], out_en, last}.
  localparam int unsigned TAG_LAST_BIT   = 0;
  localparam int unsigned TAG_OUT_EN_BIT = 1;
  localparam int unsigned TAG_ADDR_LSB   = 2;
  localparam int unsigned TAG_CTRL_BITS  = 5;

  function automatic int unsigned tag_width(input int unsigned addr_w);
    return addr_w + TAG_CTRL_BITS;
  endfunction

  function automatic int unsigned tag_init_bit(input int unsigned addr_w);
    return TAG_ADDR_LSB + addr_w;
  endfunction

  function automatic int unsigned tag_mode_bit(input int unsigned addr_w);
    return TAG_ADDR_LSB + addr_w + 1;
  endfunction

  function automatic int unsigned tag_valid_bit(input int unsigned addr_w);
    return TAG_ADDR_LSB + addr_w + 2;
  endfunction

endpackage

// File: rtl/fusion_frame_sequencer_if.sv
// Input-stream handshake between the upstream source and the sequencer.
interface fusion_frame_sequencer_if;
  logic s_axis_tvalid;
  logic s_axis_tlast;
  logic s_axis_tready;

  modport master (
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready
  );
endinterface

// File: rtl/fusion_frame_sequencer_tag_pipe.sv
// Fixed-latency tag delay line matching the datapath pipeline depth.
// Also reports how many stages currently hold a tag with COUNT_BIT set.
module fusion_tag_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 20,
  parameter int unsigned COUNT_BIT = 0,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tag_in,
  output logic [WIDTH-1:0] tag_out,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift every cycle; the pipeline cannot stall, bubbles travel as zero tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

  // Population count of flagged tags across every stage, including the one
  // presented on tag_out this cycle (it only reaches the FIFO at the next edge).
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(stage[i][COUNT_BIT]);
    end
  end

endmodule

// File: rtl/fusion_frame_sequencer.sv
// Control-plane sequencer for the frame-fusion datapath: beat/frame counting,
// AVG->FUSE phase schedule, BRAM tag issue, latency-matched write-back tags,
// output-FIFO credit throttling and tlast framing check.
module fusion_frame_sequencer
  import fusion_pkg::*;
#(
  parameter int unsigned IM_LEN            = 520,
  parameter int unsigned IM_WID            = 520,
  parameter int unsigned NO_PARALLEL_UNITS = 4,
  parameter int unsigned NO_IMAGES         = 16,
  parameter int unsigned LOG2_NO_OF_IMAGES = 4,
  parameter int unsigned PIPELINE_LATENCY  = 20,
  parameter int unsigned FIFO_DEPTH        = 32,
  localparam int unsigned BEATS  = calc_beats(IM_LEN, IM_WID, NO_PARALLEL_UNITS),
  localparam int unsigned ADDR_W = $clog2(BEATS),
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_aresetn,
  fusion_frame_sequencer_if.slave      s_axis,
  input  logic [LVL_W-1:0]             fifo_level,
  output logic                         dp_valid,
  output logic                         dp_mode,
  output logic                         dp_init,
  output logic [ADDR_W-1:0]            dp_addr,
  output logic                         wb_valid,
  output logic                         wb_mode,
  output logic                         wb_init,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic                         wb_out_en,
  output logic                         wb_last,
  output logic [LOG2_NO_OF_IMAGES-1:0] frame_idx,
  output logic                         state,
  output logic                         frame_done,
  output logic                         tlast_err
);

  localparam int unsigned TAG_W     = tag_width(ADDR_W);
  localparam int unsigned CNT_W     = $clog2(PIPELINE_LATENCY + 1);
  localparam int unsigned INIT_BIT  = tag_init_bit(ADDR_W);
  localparam int unsigned MODE_BIT  = tag_mode_bit(ADDR_W);
  localparam int unsigned VALID_BIT = tag_valid_bit(ADDR_W);

  localparam logic [ADDR_W-1:0]            LAST_BEAT  = ADDR_W'(BEATS - 1);
  localparam logic [LOG2_NO_OF_IMAGES-1:0] LAST_FRAME = LOG2_NO_OF_IMAGES'(NO_IMAGES - 1);

  fusion_state_e                  state_q;
  logic [LOG2_NO_OF_IMAGES-1:0]   frame_idx_q;
  logic [ADDR_W-1:0]              beat_q;
  logic                           tlast_err_q;
  logic                           frame_done_q;

  logic                           accept;
  logic                           ready;
  logic                           out_frame;
  logic                           at_last_beat;
  logic                           frame_end;
  logic                           init_frame;
  logic [CNT_W-1:0]               inflight_out;
  logic [TAG_W-1:0]               tag_in;
  logic [TAG_W-1:0]               tag_out;

  // Issue-side decode, all combinational from the current registers.
  always_comb begin
    out_frame    = (state_q == STATE_FUSE) && (frame_idx_q == LAST_FRAME);
    init_frame   = (state_q == STATE_AVG) && (frame_idx_q == '0);
    ready        = !out_frame ||
                   ((32'(fifo_level) + 32'(inflight_out)) < FIFO_DEPTH);
    accept       = s_axis.s_axis_tvalid && ready;
    at_last_beat = (beat_q == LAST_BEAT);
    frame_end    = accept && (at_last_beat || s_axis.s_axis_tlast);
  end

  assign s_axis.s_axis_tready = ready;

  assign dp_valid = accept;
  assign dp_mode  = logic'(state_q);
  assign dp_init  = init_frame;
  assign dp_addr  = beat_q;

  // Frame/phase state machine, framing check and frame_done pulse.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q      <= STATE_AVG;
      frame_idx_q  <= '0;
      beat_q       <= '0;
      tlast_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        // Early tlast and missing tlast both end the frame; either is an error.
        if (s_axis.s_axis_tlast != at_last_beat) begin
          tlast_err_q <= 1'b1;
        end
        if (frame_end) begin
          beat_q       <= '0;
          frame_done_q <= 1'b1;
          frame_idx_q  <= (frame_idx_q == LAST_FRAME) ? '0 : frame_idx_q + 1'b1;
          if ((state_q == STATE_AVG) && (frame_idx_q == LAST_FRAME)) begin
            state_q <= STATE_FUSE;
          end
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  assign frame_idx  = frame_idx_q;
  assign state      = logic'(state_q);
  assign frame_done = frame_done_q;
  assign tlast_err  = tlast_err_q;

  // Tag issued with every accepted beat; idle cycles inject an all-zero bubble.
  always_comb begin
    tag_in = '0;
    if (accept) begin
      tag_in = {1'b1, logic'(state_q), init_frame, beat_q,
                out_frame, out_frame && frame_end};
    end
  end

  fusion_tag_pipe #(
    .WIDTH     (TAG_W),
    .DEPTH     (PIPELINE_LATENCY),
    .COUNT_BIT (TAG_OUT_EN_BIT)
  ) u_tag_pipe (
    .clk     (s_axis_aclk),
    .rst_n   (s_axis_aresetn),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .count   (inflight_out)
  );

  assign wb_valid  = tag_out[VALID_BIT];
  assign wb_mode   = tag_out[MODE_BIT];
  assign wb_init   = tag_out[INIT_BIT];
  assign wb_addr   = tag_out[TAG_ADDR_LSB +: ADDR_W];
  assign wb_out_en = tag_out[VALID_BIT] && tag_out[TAG_OUT_EN_BIT];
  assign wb_last   = tag_out[VALID_BIT] && tag_out[TAG_OUT_EN_BIT] && tag_out[TAG_LAST_BIT];

endmodule

// File: tb/tb_fusion_frame_sequencer.sv
// Self-checking bench for fusion_frame_sequencer with a small geometry
// (8 beats/frame, latency 3, FIFO depth 4) and a write-back scoreboard.
module tb_fusion_frame_sequencer;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int NBEAT = 8;
  localparam int NIMG  = 16;

  logic       clk;
  logic       rst_n;
  logic [2:0] fifo_level;
  logic       dp_valid, dp_mode, dp_init;
  logic [2:0] dp_addr;
  logic       wb_valid, wb_mode, wb_init, wb_out_en, wb_last;
  logic [2:0] wb_addr;
  logic [3:0] frame_idx;
  logic       state, frame_done, tlast_err;

  fusion_frame_sequencer_if s_axis_if ();

  fusion_frame_sequencer #(
    .IM_LEN            (8),
    .IM_WID            (4),
    .NO_PARALLEL_UNITS (4),
    .NO_IMAGES         (16),
    .LOG2_NO_OF_IMAGES (4),
    .PIPELINE_LATENCY  (3),
    .FIFO_DEPTH        (4)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis         (s_axis_if),
    .fifo_level     (fifo_level),
    .dp_valid       (dp_valid),
    .dp_mode        (dp_mode),
    .dp_init        (dp_init),
    .dp_addr        (dp_addr),
    .wb_valid       (wb_valid),
    .wb_mode        (wb_mode),
    .wb_init        (wb_init),
    .wb_addr        (wb_addr),
    .wb_out_en      (wb_out_en),
    .wb_last        (wb_last),
    .frame_idx      (frame_idx),
    .state          (state),
    .frame_done     (frame_done),
    .tlast_err      (tlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] addr;
    logic       mode;
    logic       init;
    logic       oe;
    logic       last;
  } exp_t;

  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model of the sequencer registers
  int   m_beat, m_fidx, m_infl, max_infl;
  logic m_state, m_err, m_fd;

  // observation counters used by the scenario tasks
  int cnt_init, cnt_oe, cnt_last, cnt_fd, cnt_acc;
  logic [2:0] last_addr;

  task automatic scoreboard_loop();
    exp_t e;
    logic m_out, m_ready, m_acc, fe;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sbq.delete();
        m_beat = 0; m_fidx = 0; m_state = 1'b0; m_err = 1'b0; m_fd = 1'b0;
      end else begin
        m_infl = 0;
        foreach (sbq[k]) if (sbq[k].oe) m_infl++;
        m_out   = m_state && (m_fidx == NIMG - 1);
        m_ready = !m_out || ((DEPTH - int'(fifo_level) - m_infl) > 0);

        n_tests++;
        if (s_axis_if.s_axis_tready !== m_ready) begin
          n_fail++; $display("FAIL sb_tready cyc=%0d got=%b exp=%b", cyc, s_axis_if.s_axis_tready, m_ready);
        end
        n_tests++;
        if (state !== m_state) begin
          n_fail++; $display("FAIL sb_state cyc=%0d got=%b exp=%b", cyc, state, m_state);
        end
        n_tests++;
        if (frame_idx !== 4'(m_fidx)) begin
          n_fail++; $display("FAIL sb_frame_idx cyc=%0d got=%0d exp=%0d", cyc, frame_idx, m_fidx);
        end
        n_tests++;
        if (tlast_err !== m_err) begin
          n_fail++; $display("FAIL sb_tlast_err cyc=%0d got=%b exp=%b", cyc, tlast_err, m_err);
        end
        n_tests++;
        if (frame_done !== m_fd) begin
          n_fail++; $display("FAIL sb_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, m_fd);
        end

        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          e = sbq.pop_front();
          if (e.oe) m_infl--;
          n_tests++;
          if ({wb_valid, wb_addr, wb_mode, wb_init, wb_out_en, wb_last} !==
              {1'b1, e.addr, e.mode, e.init, e.oe, e.last}) begin
            n_fail++;
            $display("FAIL sb_wb cyc=%0d got v=%b a=%0d m=%b i=%b oe=%b l=%b exp v=1 a=%0d m=%b i=%b oe=%b l=%b",
                     cyc, wb_valid, wb_addr, wb_mode, wb_init, wb_out_en, wb_last,
                     e.addr, e.mode, e.init, e.oe, e.last);
          end
        end else begin
          n_tests++;
          if ({wb_valid, wb_out_en, wb_last} !== 3'b000) begin
            n_fail++; $display("FAIL sb_wb_idle cyc=%0d got v/oe/l=%b%b%b exp=000", cyc, wb_valid, wb_out_en, wb_last);
          end
        end

        m_acc = (s_axis_if.s_axis_tvalid === 1'b1) && m_ready;
        n_tests++;
        if (dp_valid !== m_acc) begin
          n_fail++; $display("FAIL sb_dp_valid cyc=%0d got=%b exp=%b", cyc, dp_valid, m_acc);
        end

        if (m_acc) begin
          e.due  = cyc + LAT;
          e.addr = m_beat[2:0];
          e.mode = m_state;
          e.init = !m_state && (m_fidx == 0);
          fe     = (m_beat == NBEAT - 1) || (s_axis_if.s_axis_tlast === 1'b1);
          e.oe   = m_out;
          e.last = m_out && fe;
          n_tests++;
          if ({dp_addr, dp_mode, dp_init} !== {e.addr, e.mode, e.init}) begin
            n_fail++; $display("FAIL sb_dp_tag cyc=%0d got a=%0d m=%b i=%b exp a=%0d m=%b i=%b",
                               cyc, dp_addr, dp_mode, dp_init, e.addr, e.mode, e.init);
          end
          sbq.push_back(e);
          if (e.oe) m_infl++;
          if ((s_axis_if.s_axis_tlast === 1'b1) != (m_beat == NBEAT - 1)) m_err = 1'b1;
          m_fd = fe;
          if (fe) begin
            m_beat = 0;
            if (!m_state && m_fidx == NIMG - 1) m_state = 1'b1;
            m_fidx = (m_fidx == NIMG - 1) ? 0 : m_fidx + 1;
          end else begin
            m_beat++;
          end
        end else begin
          m_fd = 1'b0;
        end
        if (m_infl > max_infl) max_infl = m_infl;

        if (dp_valid && dp_init) cnt_init++;
        if (dp_valid) cnt_acc++;
        if (wb_out_en) cnt_oe++;
        if (wb_last) begin cnt_last++; last_addr = wb_addr; end
        if (frame_done) cnt_fd++;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present n beats (tlast on index tlast_at, -1 for none), holding each until accepted.
  task automatic drive_frame(input int n, input int tlast_at);
    logic got;
    int   waited;
    for (int i = 0; i < n; i++) begin
      s_axis_if.s_axis_tvalid = 1'b1;
      s_axis_if.s_axis_tlast  = (i == tlast_at);
      got = 1'b0;
      waited = 0;
      while (!got) begin
        @(negedge clk);
        got = s_axis_if.s_axis_tready;
        @(posedge clk);
        #1;
        if (!got) begin
          waited++;
          if (waited > 200) begin
            n_tests++; n_fail++;
            $display("FAIL drive_timeout beat=%0d got=no_accept exp=accept_within_200", i);
            s_axis_if.s_axis_tvalid = 1'b0;
            s_axis_if.s_axis_tlast  = 1'b0;
            return;
          end
        end
      end
    end
    s_axis_if.s_axis_tvalid = 1'b0;
    s_axis_if.s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({dp_valid, wb_valid, wb_out_en, wb_last, frame_done, tlast_err, state, frame_idx} !== 11'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=0", {dp_valid, wb_valid, wb_out_en, wb_last, frame_done, tlast_err, state, frame_idx});
    end
    n_tests++;
    if (s_axis_if.s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_tready got=%b exp=1", s_axis_if.s_axis_tready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({dp_addr, state, frame_idx} !== 8'b0) begin
      n_fail++; $display("FAIL post_reset_regs got=%b exp=0", {dp_addr, state, frame_idx});
    end
  endtask

  task automatic test_avg_phase();
    cnt_init = 0; cnt_oe = 0;
    for (int f = 0; f < NIMG; f++) drive_frame(NBEAT, NBEAT - 1);
    repeat (LAT + 2) @(posedge clk);
    #1;
    n_tests++;
    if (cnt_init !== NBEAT) begin
      n_fail++; $display("FAIL avg_init_beats got=%0d exp=%0d", cnt_init, NBEAT);
    end
    n_tests++;
    if (cnt_oe !== 0) begin
      n_fail++; $display("FAIL avg_out_en got=%0d exp=0", cnt_oe);
    end
    n_tests++;
    if ({state, frame_idx, tlast_err} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL avg_to_fuse got st=%b fi=%0d err=%b exp st=1 fi=0 err=0", state, frame_idx, tlast_err);
    end
  endtask

  task automatic test_fuse_output();
    cnt_oe = 0; cnt_last = 0; last_addr = '0;
    for (int f = 0; f < NIMG; f++) drive_frame(NBEAT, NBEAT - 1);
    repeat (LAT + 2) @(posedge clk);
    #1;
    n_tests++;
    if (cnt_oe !== NBEAT) begin
      n_fail++; $display("FAIL fuse_out_en_count got=%0d exp=%0d", cnt_oe, NBEAT);
    end
    n_tests++;
    if (cnt_last !== 1 || last_addr !== 3'd7) begin
      n_fail++; $display("FAIL fuse_wb_last got count=%0d addr=%0d exp count=1 addr=7", cnt_last, last_addr);
    end
    n_tests++;
    if ({state, frame_idx} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL fuse_wrap got st=%b fi=%0d exp st=1 fi=0", state, frame_idx);
    end
  endtask

  task automatic test_credit();
    int base;
    for (int f = 0; f < NIMG - 1; f++) drive_frame(NBEAT, NBEAT - 1);
    fifo_level = 3'd4;
    s_axis_if.s_axis_tvalid = 1'b1;
    s_axis_if.s_axis_tlast  = 1'b0;
    base = cnt_acc;
    repeat (6) begin
      @(negedge clk);
      n_tests++;
      if (s_axis_if.s_axis_tready !== 1'b0) begin
        n_fail++; $display("FAIL credit_full_tready got=%b exp=0", s_axis_if.s_axis_tready);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (cnt_acc !== base) begin
      n_fail++; $display("FAIL credit_full_accepts got=%0d exp=0", cnt_acc - base);
    end
    fifo_level = 3'd2;
    max_infl = 0;
    cnt_oe = 0;
    drive_frame(NBEAT, NBEAT - 1);
    repeat (LAT + 2) @(posedge clk);
    #1;
    fifo_level = 3'd0;
    n_tests++;
    if (max_infl !== 2) begin
      n_fail++; $display("FAIL credit_outstanding got=%0d exp=2", max_infl);
    end
    n_tests++;
    if (cnt_oe !== NBEAT) begin
      n_fail++; $display("FAIL credit_out_en_count got=%0d exp=%0d", cnt_oe, NBEAT);
    end
  endtask

  task automatic test_early_tlast();
    int base;
    n_tests++;
    if (tlast_err !== 1'b0) begin
      n_fail++; $display("FAIL early_pre_err got=%b exp=0", tlast_err);
    end
    base = cnt_fd;
    drive_frame(5, 4);
    @(posedge clk); #1;
    n_tests++;
    if (cnt_fd - base !== 1) begin
      n_fail++; $display("FAIL early_frame_done got=%0d exp=1", cnt_fd - base);
    end
    n_tests++;
    if ({frame_idx, tlast_err} !== {4'd1, 1'b1}) begin
      n_fail++; $display("FAIL early_end got fi=%0d err=%b exp fi=1 err=1", frame_idx, tlast_err);
    end
    drive_frame(NBEAT, NBEAT - 1);
    @(posedge clk); #1;
    n_tests++;
    if ({frame_idx, tlast_err} !== {4'd2, 1'b1}) begin
      n_fail++; $display("FAIL early_sticky got fi=%0d err=%b exp fi=2 err=1", frame_idx, tlast_err);
    end
  endtask

  task automatic test_missing_tlast();
    int base;
    apply_reset();
    base = cnt_fd;
    drive_frame(NBEAT, -1);
    @(posedge clk); #1;
    n_tests++;
    if ({state, frame_idx, tlast_err} !== {1'b0, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL missing_tlast got st=%b fi=%0d err=%b exp st=0 fi=1 err=1", state, frame_idx, tlast_err);
    end
    n_tests++;
    if (cnt_fd - base !== 1) begin
      n_fail++; $display("FAIL missing_frame_done got=%0d exp=1", cnt_fd - base);
    end
  endtask

  task automatic test_reset_inflight();
    int seen;
    s_axis_if.s_axis_tvalid = 1'b1;
    s_axis_if.s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    s_axis_if.s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dp_valid, wb_valid, wb_out_en, wb_last, frame_done, tlast_err, state, frame_idx} !== 11'b0) begin
      n_fail++; $display("FAIL inflight_reset_outputs got=%b exp=0", {dp_valid, wb_valid, wb_out_en, wb_last, frame_done, tlast_err, state, frame_idx});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (wb_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL inflight_wb_after_release got=%0d exp=0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fifo_level = '0;
    s_axis_if.s_axis_tvalid = 1'b0;
    s_axis_if.s_axis_tlast  = 1'b0;
    max_infl = 0;
    cnt_init = 0; cnt_oe = 0; cnt_last = 0; cnt_fd = 0; cnt_acc = 0;
    last_addr = '0;
    fork
      scoreboard_loop();
    join_none
    test_reset();
    test_avg_phase();
    test_fuse_output();
    test_credit();
    test_early_tlast();
    test_missing_tlast();
    test_reset_inflight();
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
